// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode 7-segment scanner: steps on rising scan_clk edges, blanks anodes
// for a dead-time between digits, and snapshots digit data once per frame to avoid tearing.
module seven_seg_scanner #(
  parameter int unsigned BLANK_CYCLES = 4,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_start
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  blank_cnt_q, blank_cnt_d;
  logic        scan_q, scan_d;
  logic [15:0] shadow_digits_q, shadow_digits_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  shadow_blank_q, shadow_blank_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_start_q, frame_start_d;

  logic        tick;
  logic [3:0]  nib;
  logic [3:0]  nz;
  logic        dark;
  logic [3:0]  show_an;
  logic [6:0]  show_seg;
  logic        show_dp_n;

  // Everything the lit slot needs is derived from the shadow registers only, so inputs
  // never reach the outputs combinationally.
  always_comb begin
    tick = scan_clk & ~scan_q;
    nib  = 4'(shadow_digits_q >> {idx_q, 2'b00});
    for (int k = 0; k < 4; k++) nz[k] = |shadow_digits_q[k*4 +: 4];
    // A digit is a leading zero when it and every higher nibble are zero.
    dark = shadow_blank_q[idx_q] |
           (LZ_SUPPRESS && (idx_q != 2'd0) && !(|(nz >> idx_q)));
    show_an   = dark ? 4'hF : ~(4'b0001 << idx_q);
    show_seg  = dark ? 7'h7F : decode(nib);
    show_dp_n = dark | ~shadow_dp_q[idx_q];
  end

  // NOTE: every *_d gets a default before any branch, so no path leaves a latch behind.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    blank_cnt_d     = blank_cnt_q;
    scan_d          = scan_clk;
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_blank_d  = shadow_blank_q;
    an_d            = an_q;
    seg_d           = seg_q;
    dp_n_d          = dp_n_q;
    frame_start_d   = 1'b0;

    if (tick) begin
      idx_d       = idx_q + 2'd1;
      state_d     = ST_BLANK;
      blank_cnt_d = 8'd0;
      an_d        = 4'hF;
      seg_d       = 7'h7F;
      dp_n_d      = 1'b1;
      if (idx_q == 2'd3) begin
        shadow_digits_d = digits;
        shadow_dp_d     = dp;
        shadow_blank_d  = blank;
        frame_start_d   = 1'b1;
      end
    end else begin
      case (state_q)
        ST_BLANK: begin
          blank_cnt_d = blank_cnt_q + 8'd1;
          if (blank_cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            an_d    = show_an;
            seg_d   = show_seg;
            dp_n_d  = show_dp_n;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // scan_q resets high so a scan_clk already high at release is not seen as an edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q         <= ST_BLANK;
      idx_q           <= 2'd3;
      blank_cnt_q     <= 8'd0;
      scan_q          <= 1'b1;
      shadow_digits_q <= 16'h0000;
      shadow_dp_q     <= 4'h0;
      shadow_blank_q  <= 4'h0;
      an_q            <= 4'hF;
      seg_q           <= 7'h7F;
      dp_n_q          <= 1'b1;
      frame_start_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      blank_cnt_q     <= blank_cnt_d;
      scan_q          <= scan_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_blank_q  <= shadow_blank_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      dp_n_q          <= dp_n_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a reference model pushes the expected lit slot per
// scan step into a queue, popped when the digit lights after the dead-time.
module tb_seven_seg_scanner;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        scan_clk = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;

  logic [3:0] an, an0, an_b1;
  logic [6:0] seg, seg0, seg_b1;
  logic       dp_n, dp_n0, dp_n_b1;
  logic       frame_start, frame_start0, frame_start_b1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] an1;
    logic [6:0] seg1;
    logic       dpn1;
    logic [3:0] an0;
    logic [6:0] seg0;
    logic       dpn0;
  } exp_t;

  exp_t sb[$];

  logic [1:0]  m_idx;
  logic [15:0] s_dig;
  logic [3:0]  s_dp;
  logic [3:0]  s_blank;

  seven_seg_scanner #(.BLANK_CYCLES(4), .LZ_SUPPRESS(1'b1)) dut (
    .clk_in(clk_in), .reset(reset), .scan_clk(scan_clk), .digits(digits), .dp(dp),
    .blank(blank), .an(an), .seg(seg), .dp_n(dp_n), .frame_start(frame_start));

  seven_seg_scanner #(.BLANK_CYCLES(4), .LZ_SUPPRESS(1'b0)) dut_lz0 (
    .clk_in(clk_in), .reset(reset), .scan_clk(scan_clk), .digits(digits), .dp(dp),
    .blank(blank), .an(an0), .seg(seg0), .dp_n(dp_n0), .frame_start(frame_start0));

  seven_seg_scanner #(.BLANK_CYCLES(1), .LZ_SUPPRESS(1'b0)) dut_b1 (
    .clk_in(clk_in), .reset(reset), .scan_clk(scan_clk), .digits(digits), .dp(dp),
    .blank(blank), .an(an_b1), .seg(seg_b1), .dp_n(dp_n_b1), .frame_start(frame_start_b1));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] m_decode(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic bit m_dark(input logic [1:0] i, input bit lz);
    if (s_blank[i]) return 1'b1;
    if (!lz || i == 2'd0) return 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (k >= int'(i) && s_dig[k*4 +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_idx = 2'd3; s_dig = '0; s_dp = '0; s_blank = '0;
    sb.delete();
  endtask

  task automatic model_tick(output bit fs);
    exp_t e;
    bit d1, d0;
    fs = (m_idx == 2'd3);
    if (fs) begin s_dig = digits; s_dp = dp; s_blank = blank; end
    m_idx = m_idx + 2'd1;
    d1 = m_dark(m_idx, 1'b1);
    d0 = m_dark(m_idx, 1'b0);
    e.an1  = d1 ? 4'hF : ~(4'b0001 << m_idx);
    e.seg1 = d1 ? 7'h7F : m_decode(s_dig[m_idx*4 +: 4]);
    e.dpn1 = d1 ? 1'b1 : ~s_dp[m_idx];
    e.an0  = d0 ? 4'hF : ~(4'b0001 << m_idx);
    e.seg0 = d0 ? 7'h7F : m_decode(s_dig[m_idx*4 +: 4]);
    e.dpn0 = d0 ? 1'b1 : ~s_dp[m_idx];
    sb.push_back(e);
  endtask

  task automatic check_lit(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_an"},    32'(an),    32'(e.an1));
    chk({tag, "_seg"},   32'(seg),   32'(e.seg1));
    chk({tag, "_dpn"},   32'(dp_n),  32'(e.dpn1));
    chk({tag, "_an0"},   32'(an0),   32'(e.an0));
    chk({tag, "_seg0"},  32'(seg0),  32'(e.seg0));
    chk({tag, "_dpn0"},  32'(dp_n0), 32'(e.dpn0));
  endtask

  // One scan step: rising scan_clk, dead-time checks, then the lit slot at T+5.
  task automatic step(input string tag);
    bit   fs;
    exp_t e;
    @(negedge clk_in); scan_clk = 1'b1; model_tick(fs);
    e = sb[sb.size()-1];
    @(negedge clk_in); scan_clk = 1'b0;
    chk({tag, "_frame_start"}, 32'(frame_start), 32'(fs));
    chk({tag, "_dead1"}, 32'(an), 32'hF);
    @(negedge clk_in);
    chk({tag, "_b1_an"},  32'(an_b1),  32'(e.an0));
    chk({tag, "_b1_seg"}, 32'(seg_b1), 32'(e.seg0));
    chk({tag, "_dead2"}, 32'(an), 32'hF);
    chk({tag, "_fs_pulse"}, 32'(frame_start), 32'd0);
    repeat (2) begin
      @(negedge clk_in);
      chk({tag, "_dead"}, 32'(an), 32'hF);
    end
    @(negedge clk_in);
    check_lit(tag);
  endtask

  initial begin
    bit   fs;
    exp_t e;
    model_reset();

    // 1: reset held while scan_clk toggles and digits vary
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      scan_clk = ~scan_clk;
      digits = 16'($urandom);
      chk("rst_an",  32'(an),          32'hF);
      chk("rst_seg", 32'(seg),         32'h7F);
      chk("rst_dpn", 32'(dp_n),        32'd1);
      chk("rst_fs",  32'(frame_start), 32'd0);
    end
    @(negedge clk_in); scan_clk = 1'b1; reset = 1'b0; digits = 16'h1234;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      chk("rel_fs", 32'(frame_start), 32'd0);
      chk("rel_an", 32'(an),          32'hF);
    end
    @(negedge clk_in); scan_clk = 1'b0;

    // 2: four steps over 1234
    digits = 16'h1234; dp = 4'h0; blank = 4'h0;
    for (int i = 0; i < 4; i++) step("t2");

    // 4: change inputs mid-frame; the current frame must not tear
    step("t4a"); step("t4b");
    digits = 16'hABCD;
    step("t4c"); step("t4d");
    for (int i = 0; i < 4; i++) step("t4e");

    // 3: second tick two cycles into the dead-time restarts it
    @(negedge clk_in); scan_clk = 1'b1; model_tick(fs);
    @(negedge clk_in); scan_clk = 1'b0;
    chk("t3_fs", 32'(frame_start), 32'(fs));
    chk("t3_n1", 32'(an), 32'hF);
    @(negedge clk_in); scan_clk = 1'b1;
    chk("t3_n2", 32'(an), 32'hF);
    e = sb.pop_front();
    model_tick(fs);
    for (int i = 3; i <= 6; i++) begin
      @(negedge clk_in); scan_clk = 1'b0;
      chk("t3_dead", 32'(an), 32'hF);
      if (i == 3) chk("t3_fs2", 32'(frame_start), 32'(fs));
    end
    @(negedge clk_in);
    check_lit("t3_lit");
    step("t3b"); step("t3c");

    // 5: leading-zero suppression, decimal point, all-zero value
    digits = 16'h0050; dp = 4'b0010;
    for (int i = 0; i < 4; i++) step("t5a");
    digits = 16'h0000; dp = 4'h0;
    for (int i = 0; i < 4; i++) step("t5b");

    // 6: async reset while a digit is lit, then per-digit blank
    digits = 16'h1234; blank = 4'b0001;
    step("t6a"); step("t6b");
    #2 reset = 1'b1;
    #1;
    chk("t6_async_an",  32'(an),   32'hF);
    chk("t6_async_seg", 32'(seg),  32'h7F);
    chk("t6_async_dpn", 32'(dp_n), 32'd1);
    @(negedge clk_in); @(negedge clk_in); reset = 1'b0;
    model_reset();
    step("t6c"); step("t6d");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
